// File: rtl/mult_share_ctrl.sv
// Round-robin front end for one shared pipelined multiplier. A tag pipeline tracks which
// requester owns each product, and per-requester credits keep every result FIFO from overflowing.
module mult_share_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LATENCY   = 12,
    parameter int unsigned RES_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               res0_valid,
    input  logic               res0_ready,
    output logic [2*WIDTH-1:0] res0_prod,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               res1_valid,
    input  logic               res1_ready,
    output logic [2*WIDTH-1:0] res1_prod,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p
);

    localparam int unsigned CW = $clog2(RES_DEPTH + 1);
    localparam int unsigned PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    logic               w_req_valid [2];
    logic [WIDTH-1:0]   w_req_a     [2];
    logic [WIDTH-1:0]   w_req_b     [2];
    logic               w_res_ready [2];
    logic [CW:0]        w_used      [2];
    logic               w_eligible  [2];
    logic               w_grant     [2];
    logic               w_push      [2];
    logic               w_pop       [2];
    logic [2*WIDTH-1:0] w_head      [2];
    logic               w_issue;

    logic [CW-1:0]      r_inflight  [2];
    logic [CW-1:0]      r_cnt       [2];
    logic [PW-1:0]      r_rd_ptr    [2];
    logic [PW-1:0]      r_wr_ptr    [2];
    logic [2*WIDTH-1:0] r_mem       [2][RES_DEPTH];
    tag_t               r_tag       [LATENCY+1];
    logic               r_last_grant;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_req_valid[0] = req0_valid;
    assign w_req_valid[1] = req1_valid;
    assign w_req_a[0]     = req0_a;
    assign w_req_a[1]     = req1_a;
    assign w_req_b[0]     = req0_b;
    assign w_req_b[1]     = req1_b;
    assign w_res_ready[0] = res0_ready;
    assign w_res_ready[1] = res1_ready;

    // A requester may only issue while its outstanding plus buffered results leave FIFO room.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_used[n]     = {1'b0, r_inflight[n]} + {1'b0, r_cnt[n]};
            w_eligible[n] = !rst && w_req_valid[n] && (w_used[n] < (CW+1)'(RES_DEPTH));
        end
        w_grant[0] = w_eligible[0] && (!w_eligible[1] || r_last_grant);
        w_grant[1] = w_eligible[1] && (!w_eligible[0] || !r_last_grant);
        w_issue    = w_grant[0] || w_grant[1];
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_push[n] = r_tag[LATENCY].valid && (r_tag[LATENCY].owner == 1'(n));
            w_pop[n]  = (r_cnt[n] != '0) && w_res_ready[n];
            w_head[n] = (r_cnt[n] != '0) ? r_mem[n][r_rd_ptr[n]] : '0;
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign res0_valid = (r_cnt[0] != '0);
    assign res1_valid = (r_cnt[1] != '0);
    assign res0_prod  = w_head[0];
    assign res1_prod  = w_head[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a        <= '0;
            mul_b        <= '0;
            r_last_grant <= 1'b1;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag[k] <= '0;
            end
            for (int n = 0; n < 2; n++) begin
                r_inflight[n] <= '0;
                r_cnt[n]      <= '0;
                r_rd_ptr[n]   <= '0;
                r_wr_ptr[n]   <= '0;
            end
        end else begin
            if (w_issue) begin
                mul_a        <= w_grant[1] ? w_req_a[1] : w_req_a[0];
                mul_b        <= w_grant[1] ? w_req_b[1] : w_req_b[0];
                r_last_grant <= w_grant[1];
            end
            // The multiplier never stalls, so the tag pipe shifts unconditionally.
            r_tag[0] <= '{valid: w_issue, owner: w_grant[1]};
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            for (int n = 0; n < 2; n++) begin
                if (w_grant[n] && !w_push[n]) begin
                    r_inflight[n] <= r_inflight[n] + CW'(1);
                end else if (!w_grant[n] && w_push[n]) begin
                    r_inflight[n] <= r_inflight[n] - CW'(1);
                end
                if (w_push[n]) begin
                    r_wr_ptr[n] <= ptr_inc(r_wr_ptr[n]);
                end
                if (w_pop[n]) begin
                    r_rd_ptr[n] <= ptr_inc(r_rd_ptr[n]);
                end
                if (w_push[n] && !w_pop[n]) begin
                    r_cnt[n] <= r_cnt[n] + CW'(1);
                end else if (w_pop[n] && !w_push[n]) begin
                    r_cnt[n] <= r_cnt[n] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wr_ptr[n]] <= mul_p;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl driving a behavioural pipelined multiplier and checking
// products, arbitration order, credit back-pressure and reset flushing.
module tb_mult_share_ctrl;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned LATENCY   = 12;
    localparam int unsigned RES_DEPTH = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, res0_valid, res0_ready;
    logic        req1_valid, req1_ready, res1_valid, res1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
    logic [63:0] res0_prod, res1_prod, mul_p;

    always #5 clk = ~clk;

    mult_share_ctrl #(
        .WIDTH     (WIDTH),
        .LATENCY   (LATENCY),
        .RES_DEPTH (RES_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .res0_valid (res0_valid),
        .res0_ready (res0_ready),
        .res0_prod  (res0_prod),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res1_valid (res1_valid),
        .res1_ready (res1_ready),
        .res1_prod  (res1_prod),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p)
    );

    // Behavioural multiplier: LATENCY register stages after mul_a/mul_b.
    logic [63:0] mpipe [1:LATENCY];
    always @(posedge clk) begin
        mpipe[1] <= {32'b0, mul_a} * {32'b0, mul_b};
        for (int k = 2; k <= LATENCY; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_p = mpipe[LATENCY];

    int n_checks = 0;
    int n_errors = 0;
    int overflow_events = 0;
    int both_ready = 0;
    int valid_seen = 0;
    int cyc = 0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                if (dut.w_push[n] && !dut.w_pop[n] && dut.r_cnt[n] == 2'(RES_DEPTH))
                    overflow_events++;
            end
        end
    end

    op_t         q0[$], q1[$];
    logic [63:0] exp0[$], exp1[$];
    int          hs_cyc0[$], hs_cyc1[$], pop_cyc0[$], grant_log[$];
    bit          en0, en1, rr0, rr1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] p);
        op_t o;
        o.a = a;
        o.b = b;
        o.p = p;
        return o;
    endfunction

    function automatic int pending();
        return q0.size() + q1.size() + exp0.size() + exp1.size();
    endfunction

    // One clock cycle: drive at +1 after the edge, sample at the falling edge.
    task automatic step();
        req0_valid = en0 && (q0.size() != 0);
        req0_a     = (q0.size() != 0) ? q0[0].a : '0;
        req0_b     = (q0.size() != 0) ? q0[0].b : '0;
        req1_valid = en1 && (q1.size() != 0);
        req1_a     = (q1.size() != 0) ? q1[0].a : '0;
        req1_b     = (q1.size() != 0) ? q1[0].b : '0;
        res0_ready = rr0;
        res1_ready = rr1;
        @(negedge clk);
        if (res0_valid || res1_valid) valid_seen++;
        if (req0_ready && req1_ready) both_ready++;
        if (res0_valid && res0_ready) begin
            pop_cyc0.push_back(cyc);
            if (exp0.size() == 0) check("res0_unexpected", 64'(res0_valid), 64'd0);
            else check("res0_prod", res0_prod, exp0.pop_front());
        end
        if (res1_valid && res1_ready) begin
            if (exp1.size() == 0) check("res1_unexpected", 64'(res1_valid), 64'd0);
            else check("res1_prod", res1_prod, exp1.pop_front());
        end
        if (req0_valid && req0_ready) begin
            exp0.push_back(q0[0].p);
            hs_cyc0.push_back(cyc);
            grant_log.push_back(0);
            q0.delete(0);
        end
        if (req1_valid && req1_ready) begin
            exp1.push_back(q1[0].p);
            hs_cyc1.push_back(cyc);
            grant_log.push_back(1);
            q1.delete(0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int start = cyc;
        while (pending() > 0 && (cyc - start) < budget) step();
        check(tag, 64'(pending()), 64'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res0_ready = 1'b0;
        res1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);
        check("rst_res_valid", 64'({res1_valid, res0_valid}), 64'd0);
        check("rst_res0_prod", res0_prod, 64'd0);
        check("rst_res1_prod", res1_prod, 64'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        hs_cyc0.delete(); hs_cyc1.delete(); pop_cyc0.delete(); grant_log.delete();
        en0 = 0; en1 = 0; rr0 = 0; rr1 = 0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] g;
        int         pb;

        // First op after reset: 3*5 appears exactly LATENCY+1 cycles after the handshake.
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
        @(negedge clk);
        check("t1_ready0", 64'(req0_ready), 64'd1);
        check("t1_ready1", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("t1_mul_a", 64'(mul_a), 64'd3);
        check("t1_mul_b", 64'(mul_b), 64'd5);
        repeat (LATENCY) @(posedge clk);
        #1;
        check("t1_not_yet_valid", 64'(res0_valid), 64'd0);
        @(posedge clk);
        #1;
        check("t1_res0_valid", 64'(res0_valid), 64'd1);
        check("t1_res0_prod", res0_prod, 64'd15);
        check("t1_res1_idle", 64'(res1_valid), 64'd0);
        res0_ready = 1'b1;
        @(posedge clk);
        #1;
        res0_ready = 1'b0;
        check("t1_popped_valid", 64'(res0_valid), 64'd0);
        check("t1_popped_prod", res0_prod, 64'd0);

        // Both requesters streaming: grants alternate 0,1,0,1 from the reset tie-break.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            q0.push_back(mk_op(32'(i), 32'(i + 1), 64'(i * (i + 1))));
            q1.push_back(mk_op(32'(i + 16), 32'(i + 1), 64'((i + 16) * (i + 1))));
        end
        en0 = 1; en1 = 1; rr0 = 1; rr1 = 1;
        drain("t2_drained", 400);
        g = 4'b1111;
        for (int i = 0; i < 4 && i < grant_log.size(); i++) g[i] = (grant_log[i] != 0);
        check("t2_grant_order", 64'(g), 64'b1010);
        check("t2_first_grant_cyc", 64'((hs_cyc1.size() > 1) ? hs_cyc1[1] : -1), 64'd3);
        check("t2_res0_count", 64'(pop_cyc0.size()), 64'd6);

        // Result FIFO 0 blocked: only RES_DEPTH accepts, requester 1 keeps being served.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk_op(32'(100 + i), 32'd3, 64'((100 + i) * 3)));
            q1.push_back(mk_op(32'(i), 32'd1000, 64'(i * 1000)));
        end
        en0 = 1; en1 = 1; rr0 = 0; rr1 = 1;
        repeat (30) step();
        check("t3_accepts0", 64'(hs_cyc0.size()), 64'(RES_DEPTH));
        check("t3_ready0_low", 64'(req0_ready), 64'd0);
        check("t3_res0_full_valid", 64'(res0_valid), 64'd1);
        check("t3_req1_served", 64'(hs_cyc1.size()), 64'd4);
        rr0 = 1;
        pb  = cyc;
        drain("t3_drained", 200);
        check("t3_first_pop_cyc", 64'((pop_cyc0.size() > 0) ? pop_cyc0[0] - pb : -1), 64'd0);
        check("t3_refill_a",
              64'((hs_cyc0.size() > 2) ? hs_cyc0[2] - pop_cyc0[0] : -1), 64'd1);
        check("t3_refill_b",
              64'((hs_cyc0.size() > 3 && pop_cyc0.size() > 1) ? hs_cyc0[3] - pop_cyc0[1] : -1),
              64'd1);

        // Pop and capture on the same edge: occupancy holds, second product is not lost.
        do_reset();
        q0.push_back(mk_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000));
        q0.push_back(mk_op(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780));
        en0 = 1;
        for (int s = 0; s < 14; s++) step();
        check("t4_first_ready", 64'(res0_valid), 64'd1);
        rr0 = 1;
        step();
        rr0 = 0;
        check("t4_after_both_valid", 64'(res0_valid), 64'd1);
        check("t4_after_both_prod", res0_prod, 64'h0000_0001_2345_6780);
        rr0 = 1;
        step();
        check("t4_single_entry", 64'(res0_valid), 64'd0);
        check("t4_all_returned", 64'(pending()), 64'd0);

        // Extreme operands.
        do_reset();
        q0.push_back(mk_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001));
        q0.push_back(mk_op(32'h0000_0000, 32'hDEAD_BEEF, 64'h0));
        q1.push_back(mk_op(32'hDEAD_BEEF, 32'h0000_0000, 64'h0));
        q1.push_back(mk_op(32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF));
        en0 = 1; en1 = 1; rr0 = 1; rr1 = 1;
        drain("t5_drained", 200);

        // Reset with products in flight: nothing stale may surface afterwards.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk_op(32'(5 + i), 32'd6, 64'((5 + i) * 6)));
            q1.push_back(mk_op(32'(9 + i), 32'd2, 64'((9 + i) * 2)));
        end
        en0 = 1; en1 = 1; rr0 = 1; rr1 = 1;
        repeat (6) step();
        check("t6_in_flight", 64'(hs_cyc0.size() + hs_cyc1.size()), 64'd4);
        do_reset();
        rr0 = 1; rr1 = 1;
        valid_seen = 0;
        repeat (LATENCY + 4) step();
        check("t6_no_stale_valid", 64'(valid_seen), 64'd0);

        check("no_fifo_overflow", 64'(overflow_events), 64'd0);
        check("never_both_ready", 64'(both_ready), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
